// File: rtl/com_tx_arb.sv
// Round-robin frame scheduler for the 4-lane transmit link.
// Serialises one granted frame as nibbles, then waits for the remote ack.
module com_tx_arb #(
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_W       = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [3:0] pin_txd,
  output logic       fire_send,
  input  logic       fire_read,
  output logic       busy,
  output logic       ack_ok,
  output logic       err_timeout,
  output logic       err_underflow
);

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    HDR,
    HI,
    LO,
    TAIL,
    WAIT_ACK,
    ABORT,
    DRAIN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             grant_q;
  logic             grant_d;
  logic             last_grant_q;
  logic             last_grant_d;
  logic [7:0]       byte_q;
  logic [7:0]       byte_d;
  logic             last_q;
  logic             last_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic       sel_valid;
  logic [7:0] sel_data;
  logic       sel_last;
  logic       accept;
  logic       xfer;
  logic       timeout_hit;

  logic [3:0] txd_d;
  logic       fs_d;
  logic       busy_d;
  logic       ack_d;
  logic       to_d;
  logic       uf_d;

  assign sel_valid = grant_q ? s1_valid : s0_valid;
  assign sel_data  = grant_q ? s1_data  : s0_data;
  assign sel_last  = grant_q ? s1_last  : s0_last;

  // Byte slots: header, each non-final LO, and the drain after an abort.
  assign accept = (state_q == HDR)
                | (state_q == DRAIN)
                | ((state_q == LO) & ~last_q);

  assign s0_ready = accept & ~grant_q;
  assign s1_ready = accept &  grant_q;
  assign xfer     = accept & sel_valid;

  assign timeout_hit = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      byte_q        <= '0;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      pin_txd       <= 4'h0;
      fire_send     <= 1'b0;
      busy          <= 1'b0;
      ack_ok        <= 1'b0;
      err_timeout   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      byte_q        <= byte_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      pin_txd       <= txd_d;
      fire_send     <= fs_d;
      busy          <= busy_d;
      ack_ok        <= ack_d;
      err_timeout   <= to_d;
      err_underflow <= uf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    byte_d       = byte_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s0_valid & s1_valid) begin
          grant_d      = ~last_grant_q;
          last_grant_d = ~last_grant_q;
          state_d      = PRE;
        end else if (s0_valid) begin
          grant_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = PRE;
        end else if (s1_valid) begin
          grant_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = PRE;
        end
      end
      PRE: state_d = HDR;
      HDR: begin
        if (xfer) begin
          byte_d  = sel_data;
          last_d  = sel_last;
          state_d = HI;
        end
      end
      HI: state_d = LO;
      LO: begin
        if (last_q) begin
          state_d = TAIL;
        end else if (xfer) begin
          byte_d  = sel_data;
          last_d  = sel_last;
          state_d = HI;
        end else begin
          state_d = ABORT;
        end
      end
      TAIL: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fire_read | timeout_hit) begin
          state_d = IDLE;
        end
      end
      ABORT: state_d = DRAIN;
      DRAIN: begin
        if (xfer & sel_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    txd_d = 4'h0;
    unique case (state_d)
      PRE:     txd_d = 4'hA;
      HDR:     txd_d = {3'b000, grant_d};
      HI:      txd_d = byte_d[7:4];
      LO:      txd_d = byte_d[3:0];
      TAIL:    txd_d = 4'h5;
      ABORT:   txd_d = 4'hC;
      default: txd_d = 4'h0;
    endcase
    fs_d   = (state_d == PRE);
    busy_d = (state_d != IDLE);
    uf_d   = (state_d == ABORT);
    ack_d  = (state_q == WAIT_ACK) & fire_read;
    to_d   = (state_q == WAIT_ACK) & ~fire_read & timeout_hit;
  end

endmodule

// File: tb/tb_com_tx_arb.sv
// Scoreboard bench for com_tx_arb: per-cycle expected records are queued
// with the stimulus and compared at the falling edge.
module tb_com_tx_arb;

  logic       clk;
  logic       rst;
  logic       s0_valid;
  logic [7:0] s0_data;
  logic       s0_last;
  logic       s0_ready;
  logic       s1_valid;
  logic [7:0] s1_data;
  logic       s1_last;
  logic       s1_ready;
  logic [3:0] pin_txd;
  logic       fire_send;
  logic       fire_read;
  logic       busy;
  logic       ack_ok;
  logic       err_timeout;
  logic       err_underflow;

  com_tx_arb #(
    .ACK_TIMEOUT(16),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s0_valid(s0_valid),
    .s0_data(s0_data),
    .s0_last(s0_last),
    .s0_ready(s0_ready),
    .s1_valid(s1_valid),
    .s1_data(s1_data),
    .s1_last(s1_last),
    .s1_ready(s1_ready),
    .pin_txd(pin_txd),
    .fire_send(fire_send),
    .fire_read(fire_read),
    .busy(busy),
    .ack_ok(ack_ok),
    .err_timeout(err_timeout),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // o = {txd, fire_send, busy, ack_ok, err_timeout, err_underflow, r0, r1}
  typedef struct packed {
    logic        rst;
    logic        fr;
    logic [10:0] o;
  } rec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [3:0] gap;
  } src_t;

  typedef logic [7:0] bq_t [$];

  rec_t exp_q[$];
  src_t q0[$];
  src_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic void mk(input logic r, input logic fr,
                             input logic [3:0] txd, input logic fs,
                             input logic bz, input logic ak,
                             input logic to, input logic uf,
                             input logic r0, input logic r1);
    rec_t e;
    e.rst = r;
    e.fr  = fr;
    e.o   = {txd, fs, bz, ak, to, uf, r0, r1};
    exp_q.push_back(e);
  endfunction

  function automatic void idle(input logic ak, input logic to);
    mk(0, 0, 4'h0, 0, 0, ak, to, 0, 0, 0);
  endfunction

  // Lane trace of one frame from PRE through the last WAIT_ACK cycle.
  function automatic void exp_frame(input logic g, input bq_t b,
                                    input int nw, input logic ak);
    logic lb;
    mk(0, 0, 4'hA, 1, 1, 0, 0, 0, 0, 0);
    mk(0, 0, {3'b000, g}, 0, 1, 0, 0, 0, ~g, g);
    for (int i = 0; i < b.size(); i++) begin
      lb = (i == b.size() - 1);
      mk(0, 0, b[i][7:4], 0, 1, 0, 0, 0, 0, 0);
      mk(0, 0, b[i][3:0], 0, 1, 0, 0, 0, ~g & ~lb, g & ~lb);
    end
    mk(0, 0, 4'h5, 0, 1, 0, 0, 0, 0, 0);
    for (int w = 0; w < nw; w++)
      mk(0, ak && (w == nw - 1), 4'h0, 0, 1, 0, 0, 0, 0, 0);
  endfunction

  function automatic void src_frame(input int s, input bq_t b,
                                    input int gi, input int gv);
    src_t t;
    for (int i = 0; i < b.size(); i++) begin
      t.d   = b[i];
      t.l   = (i == b.size() - 1);
      t.gap = (i == gi) ? 4'(gv) : 4'd0;
      if (s == 0) q0.push_back(t);
      else q1.push_back(t);
    end
  endfunction

  task automatic drive_src();
    src_t t;
    if (q0.size() > 0 && q0[0].gap != 0) begin
      t = q0[0];
      t.gap = t.gap - 4'd1;
      q0[0] = t;
    end
    if (q1.size() > 0 && q1[0].gap != 0) begin
      t = q1[0];
      t.gap = t.gap - 4'd1;
      q1[0] = t;
    end
    s0_valid = (q0.size() > 0) && (q0[0].gap == 0);
    s0_data  = (q0.size() > 0) ? q0[0].d : 8'h00;
    s0_last  = (q0.size() > 0) ? q0[0].l : 1'b0;
    s1_valid = (q1.size() > 0) && (q1[0].gap == 0);
    s1_data  = (q1.size() > 0) ? q1[0].d : 8'h00;
    s1_last  = (q1.size() > 0) ? q1[0].l : 1'b0;
  endtask

  // One clock: apply the record's stimulus, sample at negedge, hand back
  // observed outputs and the popped expectation.
  task automatic cycle(output logic [10:0] obs, output rec_t e);
    logic h0;
    logic h1;
    e = exp_q[0];
    rst = e.rst;
    fire_read = e.fr;
    @(negedge clk);
    obs = {pin_txd, fire_send, busy, ack_ok, err_timeout,
           err_underflow, s0_ready, s1_ready};
    h0 = s0_valid & s0_ready;
    h1 = s1_valid & s1_ready;
    void'(exp_q.pop_front());
    cyc++;
    @(posedge clk);
    #1;
    if (h0) void'(q0.pop_front());
    if (h1) void'(q1.pop_front());
    drive_src();
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    rec_t e;
    q0.push_back('{d: 8'h5A, l: 1'b1, gap: 4'd0});
    drive_src();
    for (int i = 0; i < 3; i++)
      mk(1, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      cycle(obs, e);
      checks++;
      if (obs !== e.o) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b expected %b", cyc, obs, e.o);
      end
    end
    q0.delete();
    drive_src();
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [10:0] obs;
    rec_t e;
    bq_t b;
    b = {8'h11}; src_frame(0, b, -1, 0);
    b = {8'h33}; src_frame(0, b, -1, 0);
    b = {8'h22}; src_frame(1, b, -1, 0);
    b = {8'h44}; src_frame(1, b, -1, 0);
    drive_src();
    idle(0, 0);
    b = {8'h11}; exp_frame(0, b, 1, 1); idle(1, 0);
    b = {8'h22}; exp_frame(1, b, 1, 1); idle(1, 0);
    b = {8'h33}; exp_frame(0, b, 1, 1); idle(1, 0);
    b = {8'h44}; exp_frame(1, b, 1, 1); idle(1, 0);
    idle(0, 0);
    while (exp_q.size() > 0) begin
      cycle(obs, e);
      checks++;
      if (obs !== e.o) begin
        errors++;
        $display("FAIL round_robin cyc%0d: got %b expected %b",
                 cyc, obs, e.o);
      end
    end
  endtask

  task automatic test_single_byte();
    logic [10:0] obs;
    rec_t e;
    bq_t b;
    b = {8'h3C};
    src_frame(0, b, -1, 0);
    drive_src();
    idle(0, 0);
    exp_frame(0, b, 4, 1);
    idle(1, 0);
    idle(0, 0);
    while (exp_q.size() > 0) begin
      cycle(obs, e);
      checks++;
      if (obs !== e.o) begin
        errors++;
        $display("FAIL single_byte cyc%0d: got %b expected %b",
                 cyc, obs, e.o);
      end
    end
  endtask

  task automatic test_multi_byte();
    logic [10:0] obs;
    rec_t e;
    bq_t b;
    b = {8'h12, 8'h34, 8'h56};
    src_frame(1, b, -1, 0);
    drive_src();
    idle(0, 0);
    exp_frame(1, b, 2, 1);
    idle(1, 0);
    idle(0, 0);
    while (exp_q.size() > 0) begin
      cycle(obs, e);
      checks++;
      if (obs !== e.o) begin
        errors++;
        $display("FAIL multi_byte cyc%0d: got %b expected %b",
                 cyc, obs, e.o);
      end
    end
  endtask

  task automatic test_timeout();
    logic [10:0] obs;
    rec_t e;
    bq_t b;
    b = {8'h77};
    src_frame(0, b, -1, 0);
    drive_src();
    idle(0, 0);
    exp_frame(0, b, 16, 0);
    idle(0, 1);
    idle(0, 0);
    while (exp_q.size() > 0) begin
      cycle(obs, e);
      checks++;
      if (obs !== e.o) begin
        errors++;
        $display("FAIL timeout cyc%0d: got %b expected %b",
                 cyc, obs, e.o);
      end
    end
    b = {8'h88};
    src_frame(1, b, -1, 0);
    drive_src();
    idle(0, 0);
    exp_frame(1, b, 16, 1);
    idle(1, 0);
    idle(0, 0);
    while (exp_q.size() > 0) begin
      cycle(obs, e);
      checks++;
      if (obs !== e.o) begin
        errors++;
        $display("FAIL ack_at_timeout cyc%0d: got %b expected %b",
                 cyc, obs, e.o);
      end
    end
  endtask

  task automatic test_underflow();
    logic [10:0] obs;
    rec_t e;
    bq_t b;
    b = {8'hA1, 8'hB2, 8'hC3};
    src_frame(0, b, 1, 4);
    drive_src();
    idle(0, 0);
    mk(0, 0, 4'hA, 1, 1, 0, 0, 0, 0, 0);
    mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 0);
    mk(0, 0, 4'hA, 0, 1, 0, 0, 0, 0, 0);
    mk(0, 0, 4'h1, 0, 1, 0, 0, 0, 1, 0);
    mk(0, 0, 4'hC, 0, 1, 0, 0, 1, 0, 0);
    mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 0);
    mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 0);
    idle(0, 0);
    idle(0, 0);
    while (exp_q.size() > 0) begin
      cycle(obs, e);
      checks++;
      if (obs !== e.o) begin
        errors++;
        $display("FAIL underflow cyc%0d: got %b expected %b",
                 cyc, obs, e.o);
      end
    end
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL underflow_drain: got %0d bytes left, expected 0",
               q0.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] obs;
    rec_t e;
    bq_t b;
    b = {8'h9A, 8'hBC, 8'hDE, 8'hF0};
    src_frame(0, b, -1, 0);
    drive_src();
    idle(0, 0);
    mk(0, 0, 4'hA, 1, 1, 0, 0, 0, 0, 0);
    mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 0);
    mk(1, 0, 4'h9, 0, 1, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      cycle(obs, e);
      checks++;
      if (obs !== e.o) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: got %b expected %b",
                 cyc, obs, e.o);
      end
    end
    q0.delete();
    drive_src();
    idle(0, 0);
    idle(0, 0);
    while (exp_q.size() > 0) begin
      cycle(obs, e);
      checks++;
      if (obs !== e.o) begin
        errors++;
        $display("FAIL after_reset cyc%0d: got %b expected %b",
                 cyc, obs, e.o);
      end
    end
    src_frame(0, b, -1, 0);
    drive_src();
    idle(0, 0);
    exp_frame(0, b, 3, 1);
    idle(1, 0);
    idle(0, 0);
    while (exp_q.size() > 0) begin
      cycle(obs, e);
      checks++;
      if (obs !== e.o) begin
        errors++;
        $display("FAIL re_present cyc%0d: got %b expected %b",
                 cyc, obs, e.o);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    fire_read = 1'b0;
    drive_src();
    test_reset();
    test_round_robin();
    test_single_byte();
    test_multi_byte();
    test_timeout();
    test_underflow();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of tests");
    $fatal(1);
  end

endmodule

// File: doc/com_tx_arb.md
Name: com_tx_arb

Overview:
- Frame scheduler that drives the 4-lane differential transmit link (pin_txd / fire_send) and monitors the single-bit remote acknowledge (fire_read).
- Arbitrates round-robin between two byte-stream requesters: source 0 carries data, source 1 carries commands.
- Serialises one granted frame at a time as nibbles, then waits for the remote ack or a timeout.
- Sits between the packet builders and the LVDS pin buffer block.

Parameters:
- ACK_TIMEOUT, 1024: cycles spent in WAIT_ACK before err_timeout is declared (minimum 2).
- CNT_W, 11: width of the ack timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- s0_valid  input  1  source 0 byte valid
- s0_data  input  8  source 0 byte
- s0_last  input  1  source 0 final byte of frame
- s0_ready  output  1  source 0 byte accepted this cycle
- s1_valid, s1_data[7:0], s1_last, s1_ready: same as source 0, for source 1
- pin_txd  output  4  lane nibble to the pin buffer
- fire_send  output  1  frame-start strobe
- fire_read  input  1  remote ack level
- busy  output  1  high in any state other than IDLE
- ack_ok  output  1  one-cycle pulse when the ack is received
- err_timeout  output  1  one-cycle pulse when the ack times out
- err_underflow  output  1  one-cycle pulse on mid-frame starvation

Behaviour:
- Reset state: IDLE. Reset value of every output is 0 (pin_txd=4'h0; fire_send, s*_ready, busy, ack_ok, err_* all 0). Internal state on reset: last_grant=1, byte register and counter cleared.
- Reset asserted mid-frame takes effect on the next edge. No tail or abort nibble is emitted after reset.
- Sources follow valid/ready rules: once valid is high, valid, data and last are held until ready. A byte transfers on a cycle where valid and ready are both high.
- All outputs are registered except s*_ready, which decodes combinationally from state and grant.

State machine (pin_txd value shown per state):
- IDLE (pin_txd=0):
  - If exactly one source is valid, grant it.
  - If both are valid, grant the source opposite last_grant, then update last_grant.
  - On a grant, go to PRE.
- PRE: pin_txd=4'hA, fire_send=1 for exactly this cycle. Go to HDR.
- HDR: pin_txd={3'b000,grant}; ready[grant]=1. Latch the byte and last flag. Go to HI.
- HI: pin_txd=byte[7:4]. Go to LO.
- LO: pin_txd=byte[3:0].
  - If the latched last=1: ready=0, go to TAIL.
  - Else ready[grant]=1. If valid, latch the next byte and go to HI. If not valid, go to ABORT.
- TAIL: pin_txd=4'h5. Clear the counter. Go to WAIT_ACK.
- WAIT_ACK (pin_txd=0; counter increments every cycle):
  - If fire_read=1, pulse ack_ok and go to IDLE.
  - Else, when counter==ACK_TIMEOUT-1, pulse err_timeout and go to IDLE.
  - If fire_read and the timeout coincide, ack wins.
- ABORT: pin_txd=4'hC for one cycle, err_underflow pulses. Go to DRAIN.
- DRAIN: pin_txd=0; ready[grant]=1. Discard bytes. When a byte with last=1 is accepted, go to IDLE. No ack wait.

Other rules:
- fire_read is ignored outside WAIT_ACK.
- The non-granted source's ready is always 0.
- Frame of N bytes: lane occupancy is 2N+3 cycles (PRE, HDR, 2N data nibbles, TAIL). The first byte is accepted 2 cycles after the grant decision.
- Back-to-back frames: minimum gap is one IDLE cycle after WAIT_ACK exits.

Test Plan:
- Source 0 sends one byte 0x3C with last=1, fire_read is raised 4 cycles after TAIL → pin_txd sequence A,0,3,C,5,0...; fire_send high only in the PRE cycle; ack_ok pulses once; busy drops the cycle after.
- Both sources are valid in the same IDLE cycle after reset → source 0 granted first (header nibble 0). After that frame's ack, source 1 is granted (header nibble 1). Alternation continues while both are valid.
- Source 1 sends 3-byte frame 0x12,0x34,0x56 → nibbles A,1,1,2,3,4,5,6,5. s1_ready is high exactly in the HDR, LO(byte 0x12) and LO(byte 0x34) cycles.
- fire_read is held low with ACK_TIMEOUT=16 → err_timeout pulses exactly 16 cycles after WAIT_ACK is entered, then IDLE. Also: fire_read=1 on the timeout cycle → ack_ok pulses, err_timeout does not.
- Source 0 drops valid before the second byte of a 3-byte frame → pin_txd=C for one cycle, err_underflow pulses. Remaining bytes are drained through last with no lane activity, no ack wait, then IDLE.
- rst asserted during HI of a 4-byte frame → the next cycle shows all outputs at 0 and state IDLE. A frame re-presented after reset starts cleanly from PRE.
